ofdm_rx_output_buffer: RTL
==========================

OFDM_RX_OUTPUT_BUFFER -- requirements
Module: ofdm_rx_output_buffer

Interface
REQ-001 Parameter FRAME_BITS, default 224: bits per frame word.
REQ-002 Parameter CNT_W, default 8: bit-counter width, at least clog2(FRAME_BITS).
REQ-003 Port clk, input, 1: single clock; all logic is clocked on the rising edge.
REQ-004 Port nreset, input, 1: asynchronous, active-low reset.
REQ-005 Port din, input, 1: serial demodulated data bit.
REQ-006 Port din_valid, input, 1: din carries a valid bit.
REQ-007 Port din_sof, input, 1: qualified by din_valid; marks the current bit as frame bit 0.
REQ-008 Port din_rready, output, 1: block can accept a bit this cycle.
REQ-009 Port dout, output, FRAME_BITS: assembled frame word.
REQ-010 Port dout_valid, output, 1: dout holds a complete frame.
REQ-011 Port dout_wready, input, 1: downstream accepts dout this cycle.
REQ-012 Port sync_err, output, 1: sticky flag; a din_sof arrived mid-frame.

Function
REQ-013 A bit is accepted on a cycle where din_valid=1 and din_rready=1.
REQ-014 Frame bit k is stored in dout[k], so bit 0 is the LSB and the first bit received.
REQ-015 Assembly register asm[FRAME_BITS-1:0] and counter cnt (0..FRAME_BITS-1) advance only on an accepted bit: asm[cnt] <= din, cnt <= cnt+1.
REQ-016 Completion is an accepted bit with cnt=FRAME_BITS-1; cnt then wraps to 0.
REQ-017 The FSM has two states, FILL and STALL; reset enters FILL.
REQ-018 FILL: din_rready=1.
REQ-019 Completion in FILL, output slot free (dout_valid=0, or dout_valid=1 and dout_wready=1 in the same cycle): at the next edge dout <= completed word including the final bit, dout_valid=1, and the state stays FILL.
REQ-020 Completion in FILL, output slot occupied (dout_valid=1 and dout_wready=0): at the next edge the state goes to STALL and asm holds the full word.
REQ-021 STALL: din_rready=0.
REQ-022 STALL with dout_wready=1: at the next edge dout <= asm, dout_valid stays 1, cnt=0 and the state goes to FILL.
REQ-023 Output handshake: a word is transferred when dout_valid=1 and dout_wready=1.
REQ-024 On a transfer with no reload, dout_valid <= 0 at the next edge.
REQ-025 dout shall not change while dout_valid=1 and dout_wready=0.
REQ-026 Latency: dout_valid rises exactly 1 cycle after the completing bit is accepted when the slot is free.
REQ-027 Throughput: back-to-back frames with no bubbles when dout_wready is held at 1.
REQ-028 din_sof accepted with cnt=0: normal frame start.
REQ-029 din_sof accepted with cnt!=0: the partial frame is discarded, the bit is written to asm[0], cnt <= 1, and sync_err <= 1.
REQ-030 din_sof is ignored when the bit is not accepted.
REQ-031 sync_err, once set, holds until reset.
REQ-032 din_sof on the completing position (cnt=FRAME_BITS-1, cnt!=0) follows REQ-029, not REQ-016; no word is emitted.
REQ-033 asm is not cleared between frames; every bit of a frame is overwritten before emission, so no clear is needed.

Reset
REQ-034 While nreset=0, immediately and independent of clk: state=FILL, cnt=0, asm=0, dout=0, dout_valid=0, sync_err=0.
REQ-035 While nreset=0, din_rready=0 (gated by reset).
REQ-036 Reset mid-frame or in STALL discards all partial and held data.
REQ-037 The first bit after reset release is frame bit 0, regardless of din_sof.
REQ-038 din_rready=1 from the first clk edge after reset release.

Structure
REQ-039 Shared package ofdm_pkg holds FRAME_BITS=224, CNT_W=8 and the FSM state enumeration {FILL, STALL}; the matching TX buffer uses the same FRAME_BITS.
REQ-040 Single module, no sub-modules; the bit counter and FSM are inline.
REQ-041 All state is registered; din_rready is decoded from state and reset only, with no combinational path from din_valid or dout_wready.

Verification
REQ-042 Feed 224 bits of pattern 0xA5 repeating, LSB first, with dout_wready=1 -> dout_valid=1 one cycle after bit 223; dout equals the pattern; dout_valid drops the next cycle.
REQ-043 Hold dout_wready=0 and feed two full frames -> after the second completion din_rready=0 and dout keeps frame 1; raise dout_wready -> frame 2 appears the next cycle and din_rready returns to 1.
REQ-044 Feed 100 bits, then din_sof with 224 bits of all-ones -> sync_err=1, dout=all-ones, and no word is emitted for the 100-bit fragment.
REQ-045 Stream three frames continuously with dout_wready=1 -> three dout_valid pulses, 224 cycles apart, with correct data.
REQ-046 Assert nreset=0 in STALL and in mid-frame (bit 57) -> all outputs read 0 asynchronously; after release, a fresh 224-bit frame is assembled correctly.
REQ-047 Toggle din_valid randomly at 50% duty on one frame -> dout is identical to the gap-free case.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared OFDM frame constants and the RX/TX buffer FSM state encoding.
package ofdm_pkg;

    localparam int unsigned FRAME_BITS = 224;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/ofdm_rx_output_buffer.sv
// Serial-to-parallel frame assembler: collects FRAME_BITS demodulated bits LSB first
// and presents each completed frame word through a valid/ready output slot.
module ofdm_rx_output_buffer #(
    parameter int unsigned FRAME_BITS = ofdm_pkg::FRAME_BITS,
    parameter int unsigned CNT_W      = ofdm_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  din_sof,
    output logic                  din_rready,
    output logic [FRAME_BITS-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_wready,
    output logic                  sync_err
);

    import ofdm_pkg::state_t;
    import ofdm_pkg::FILL;
    import ofdm_pkg::STALL;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [FRAME_BITS-1:0] asm;

    logic accept;
    logic resync;
    logic slot_free;
    logic xfer;

    assign din_rready = nreset && (state == FILL);
    assign accept     = din_valid && din_rready;
    // A start-of-frame anywhere but position 0 restarts assembly, even on the last bit.
    assign resync     = accept && din_sof && (cnt != '0);
    assign xfer       = dout_valid && dout_wready;
    assign slot_free  = !dout_valid || dout_wready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= FILL;
            cnt        <= '0;
            asm        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    // Drop valid on a transfer; a completion below re-asserts it.
                    if (xfer) begin
                        dout_valid <= 1'b0;
                    end
                    if (resync) begin
                        asm[0]   <= din;
                        cnt      <= CNT_W'(1);
                        sync_err <= 1'b1;
                    end else if (accept) begin
                        asm[cnt] <= din;
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (slot_free) begin
                                dout       <= {din, asm[FRAME_BITS-2:0]};
                                dout_valid <= 1'b1;
                            end else begin
                                state <= STALL;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                STALL: begin
                    // dout_valid is necessarily 1 here and stays 1 across the reload.
                    if (dout_wready) begin
                        dout  <= asm;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
